booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Sequential radix-2 Booth multiplier for two's-complement operands of parametrised width.
//  Performs one Booth step per clock, so a product takes WIDTH cycles.
//  Uses a start/done handshake and holds the product until the next operation is accepted.
//  The add/subtract datapath is a ripple chain of the library full-adder cell.
//  It is the top-level arithmetic engine of the Booth multiplication design.
// PARAMETERS
//  WIDTH   8   operand width in bits (>= 2); product is 2*WIDTH bits
//  CNT_W   $clog2(WIDTH+1)   iteration counter width (derived; do not override)
// PORTS
//  clk           input   1          single clock; all state updates on rising edge
//  rst           input   1          synchronous, active-high reset
//  start         input   1          request a multiply; sampled only when accepting (see below)
//  multiplicand  input   WIDTH      signed operand M, captured on an accepted start
//  multiplier    input   WIDTH      signed operand Q, captured on an accepted start
//  busy          output  1          high while iterating (state RUN)
//  done          output  1          one-cycle pulse: product valid and newly updated
//  product       output  2*WIDTH    signed M*Q; held stable between done pulses
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, product=0, all internal registers 0.
//  - rst takes priority over every other input.
//  - rst asserted mid-RUN abandons the operation; no done pulse is produced.
//  States:
//  - IDLE: busy=0, done=0.
//  - RUN:  busy=1, done=0.
//  - DONE: busy=0, done=1, lasting exactly one cycle.
//  Accept: start=1 at an edge while state is IDLE or DONE.
//  - Captures M.
//  - Loads A=0 (WIDTH+1 bits, sign-extended accumulator), Qreg=multiplier, q_1=0, count=0.
//  - Next state is RUN.
//  - start while in RUN is ignored; operands are not recaptured.
//  RUN, each edge:
//  - Select on {Qreg[0], q_1}: 01 -> A=A+sext(M); 10 -> A=A-sext(M); 00/11 -> A unchanged.
//    Subtraction is A + ~sext(M) + 1 through the same adder (carry-in = 1).
//  - Then arithmetic shift right of {A,Qreg,q_1} by one; the A MSB is replicated.
//  - count increments.
//  - When count reaches WIDTH-1 (this is the final step), the same edge updates
//    product = {A[WIDTH-1:0],Qreg} (post-shift) and moves to DONE.
//  Latency: the accepting edge is edge k. done is high in the cycle following edge
//  k+WIDTH, and product is valid from that edge.
//  DONE: returns to IDLE on the next edge, or re-enters RUN if start=1 (back-to-back
//  operations, no idle cycle required).
//  Width rules:
//  - The accumulator is WIDTH+1 bits so that M = -2^(WIDTH-1) cannot overflow.
//  - Adder carry-out is discarded.
//  - product is exact for the full signed range, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
//  Operand inputs may change freely after the accept edge.
// STRUCTURE
//  Shared package: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2, plus Booth
//  select codes (NOP/ADD/SUB) as localparams.
//  Sub-module booth_addsub (WIDTH+1 bits):
//  - A ripple chain of fa cells; operand b is XORed with sub, and cin = sub.
//  - Purely combinational; instantiated once.
//  Top level contains the FSM, counter, {A,Qreg,q_1} shift register and product register.
// TESTING (WIDTH=8 unless noted)
//  - M=3, Q=5, start pulse -> busy high 8 cycles; done pulses 8 cycles after accept; product=16'h000F.
//  - M=-7, Q=6 -> product=16'hFFD6 (-42); M=6, Q=-7 -> same result.
//  - M=-128, Q=-128 -> 16'h4000; M=-128, Q=127 -> 16'hC080; M=0, Q=-1 -> 16'h0000.
//  - start toggled during RUN with new operands -> ignored; first result delivered unchanged.
//  - rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, product=0; a new start
//    then yields a correct result.
//  - Back-to-back: start held high across DONE -> second result follows with no gap.
//  - WIDTH=4: exhaustive 256 operand pairs checked against a behavioural signed multiply.

Source files
------------

// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//  state_t   : controller states (IDLE/RUN/DONE)
//  SEL_*     : Booth step select codes
//  booth_sel : maps {Qreg[0], q_1} to a select code
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_NOP = 2'b00;
  localparam logic [1:0] SEL_ADD = 2'b01;
  localparam logic [1:0] SEL_SUB = 2'b10;

  // Radix-2 Booth recoding: 01 -> +M, 10 -> -M, 00/11 -> no change.
  function automatic logic [1:0] booth_sel(input logic q0, input logic q_1);
    logic [1:0] code;
    code = SEL_NOP;
    case ({q0, q_1})
      2'b01:   code = SEL_ADD;
      2'b10:   code = SEL_SUB;
      default: code = SEL_NOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/booth_mult_seq_addsub.sv
// Ripple-carry adder/subtractor built from full-adder cells.
//  fa           : single-bit full adder (a, b, cin -> sum, cout)
//  booth_addsub : sum = a + (b ^ {sub}) + sub, i.e. a+b or a-b
//    a, b  : input  WIDTH   operands
//    sub   : input  1       1 selects subtraction
//    sum   : output WIDTH   result
//    cout  : output 1       carry out of the MSB cell
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module booth_addsub #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = sub;
  assign cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa u_fa (
      .a   (a[i]),
      .b   (b[i] ^ sub),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock.
//  clk          : input   clock, rising edge
//  rst          : input   synchronous active-high reset
//  start        : input   request; accepted in IDLE or DONE
//  multiplicand : input   WIDTH signed operand M
//  multiplier   : input   WIDTH signed operand Q
//  busy         : output  high while iterating
//  done         : output  one-cycle pulse when product is updated
//  product      : output  2*WIDTH signed M*Q, held between done pulses
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_1;
  logic [CNT_W-1:0] count;

  logic [1:0]       sel;
  logic             sub_op;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;
  logic             add_cout_unused;
  logic [WIDTH:0]   a_step;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;

  assign sel    = booth_sel(q_reg[0], q_1);
  assign sub_op = (sel == SEL_SUB);
  assign m_ext  = {m_reg[WIDTH-1], m_reg};

  booth_addsub #(.WIDTH(WIDTH + 1)) u_addsub (
    .a   (a_reg),
    .b   (m_ext),
    .sub (sub_op),
    .sum (sum),
    .cout(add_cout_unused)
  );

  // Add/sub result, then arithmetic right shift of {A, Qreg, q_1}.
  always_comb begin
    a_step = (sel == SEL_NOP) ? a_reg : sum;
    a_sh   = {a_step[WIDTH], a_step[WIDTH:1]};
    q_sh   = {a_step[0], q_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= multiplicand;
            a_reg <= '0;
            q_reg <= multiplier;
            q_1   <= 1'b0;
            count <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_reg <= a_sh;
          q_reg <= q_sh;
          q_1   <= q_reg[0];
          count <= count + CNT_W'(1);
          // Final step: capture the post-shift value directly into product.
          if (count == LAST_STEP) begin
            product <= {a_sh[WIDTH-1:0], q_sh};
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (WIDTH=8 and WIDTH=4).
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        start4;
  logic [3:0]  mcand4;
  logic [3:0]  mplier4;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .multiplicand(mcand),
    .multiplier  (mplier),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  booth_mult_seq #(.WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .multiplicand(mcand4),
    .multiplier  (mplier4),
    .busy        (busy4),
    .done        (done4),
    .product     (product4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until done is seen (bounded); n = edges taken, nbusy = busy cycles seen before done.
  task automatic wait_done8(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    do begin
      step();
      n++;
      if (busy && !done) nbusy++;
    end while (!done && n < 40);
  endtask

  task automatic mul8(input string tag, input logic [7:0] m, input logic [7:0] q,
                      input logic [15:0] exp);
    int n, nb;
    start  = 1'b1;
    mcand  = m;
    mplier = q;
    step();
    start  = 1'b0;
    mcand  = ~m;
    mplier = ~q;
    check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
    wait_done8(n, nb);
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_busy_cycles"}, 32'(nb + 1), 32'd8);
    check({tag, "_product"}, 32'(product), 32'(exp));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    step();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_product_held"}, 32'(product), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, late, ma, qa, e;
    logic seen;
    logic [31:0] ev;

    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    start4 = 1'b0; mcand4 = '0; mplier4 = '0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_product4", 32'(product4), 32'd0);
    rst = 1'b0;
    step();

    mul8("m3_q5", 8'h03, 8'h05, 16'h000F);
    mul8("mn7_q6", 8'hF9, 8'h06, 16'hFFD6);
    mul8("m6_qn7", 8'h06, 8'hF9, 16'hFFD6);
    mul8("mn128_qn128", 8'h80, 8'h80, 16'h4000);
    mul8("mn128_q127", 8'h80, 8'h7F, 16'hC080);
    mul8("m0_qn1", 8'h00, 8'hFF, 16'h0000);

    // start during RUN with new operands must be ignored
    start = 1'b1; mcand = 8'h03; mplier = 8'h05;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; mcand = 8'h09; mplier = 8'h09;
    step();
    start = 1'b0;
    wait_done8(n, nb);
    check("ignore_start_latency", 32'(n), 32'd5);
    check("ignore_start_product", 32'(product), 32'h000F);
    step();

    // reset in the middle of RUN
    start = 1'b1; mcand = 8'hF9; mplier = 8'h06;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_product", 32'(product), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | done | busy;
    end
    check("midrun_rst_no_done", 32'(seen), 32'd0);
    mul8("after_rst", 8'h06, 8'hF9, 16'hFFD6);

    // back-to-back with start held high across DONE
    start = 1'b1; mcand = 8'h03; mplier = 8'h05;
    step();
    mcand = 8'h80; mplier = 8'h7F;
    wait_done8(n, nb);
    check("b2b_first_latency", 32'(n), 32'd8);
    check("b2b_first_product", 32'(product), 32'h000F);
    step();
    start = 1'b0;
    check("b2b_reaccept_busy", 32'(busy), 32'd1);
    check("b2b_reaccept_done", 32'(done), 32'd0);
    wait_done8(n, nb);
    check("b2b_second_latency", 32'(n), 32'd8);
    check("b2b_second_product", 32'(product), 32'hC080);
    step();

    // WIDTH=4 exhaustive against a behavioural signed multiply
    late = 0;
    for (int mi = 0; mi < 16; mi++) begin
      for (int qi = 0; qi < 16; qi++) begin
        start4 = 1'b1;
        mcand4 = 4'(mi);
        mplier4 = 4'(qi);
        step();
        start4 = 1'b0;
        n = 0;
        do begin
          step();
          n++;
        end while (!done4 && n < 20);
        if (n != 4) late++;
        ma = (mi > 7) ? mi - 16 : mi;
        qa = (qi > 7) ? qi - 16 : qi;
        e  = ma * qa;
        ev = 32'(e) & 32'h0000_00FF;
        check("w4_product", 32'(product4), ev);
      end
    end
    check("w4_latency_errors", 32'(late), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
